mul_div_unit: RTL and testbench

Iterative multiply/divide unit for the multi-cycle MIPS datapath: executes MULT, MULTU, DIV and DIVU on parametrised-width operands and holds the result in internal HI/LO registers until the next completion. It generalises the shift-add multiplier with several additions: signed operation, restoring division, a busy/done handshake, asynchronous reset, and result retention. The control unit stalls on `busy` and reads `hi`/`lo` for MFHI/MFLO.

---
 rtl/mul_div_unit.sv | 201 ++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: MULTU, MULT, DIVU and DIV over WIDTH-bit
// operands. One shift-add or restoring-divide step runs per cycle on the
// operand magnitudes. A final cycle applies the sign correction and writes HI/LO,
// which then hold until the next completion or reset.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Operand signs and magnitudes as seen in the start cycle; the most
  // negative value negates to itself, which read unsigned is 2^(WIDTH-1).
  logic             in_neg_a, in_neg_b;
  logic [WIDTH-1:0] in_mag_a, in_mag_b;

  // Datapath for one iteration step and for the final correction.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   quot_neg;
  logic [WIDTH-1:0]   rem_neg;
  logic               signs_differ;

  // Magnitudes of the incoming operands plus the shared step datapath.
  always_comb begin
    in_neg_a     = op[0] & a[WIDTH-1];
    in_neg_b     = op[0] & b[WIDTH-1];
    in_mag_a     = in_neg_a ? (~a + WIDTH'(1)) : a;
    in_mag_b     = in_neg_b ? (~b + WIDTH'(1)) : b;
    mul_sum      = {1'b0, acc_q} + (sh_q[0] ? {1'b0, mag_q} : {(WIDTH+1){1'b0}});
    div_shift    = {acc_q, sh_q[WIDTH-1]};
    div_trial    = div_shift - {1'b0, mag_q};
    prod         = {acc_q, sh_q};
    prod_neg     = ~prod + (2*WIDTH)'(1);
    quot_neg     = ~sh_q + WIDTH'(1);
    rem_neg      = ~acc_q + WIDTH'(1);
    signs_differ = sign_a_q ^ sign_b_q;
  end

  // Next-state logic: accept in IDLE, iterate WIDTH times in RUN, then FIX.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    a_raw_d  = a_raw_q;
    mag_d    = mag_q;
    acc_d    = acc_q;
    sh_d     = sh_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          cnt_d    = '0;
          op_d     = op;
          sign_a_d = in_neg_a;
          sign_b_d = in_neg_b;
          a_raw_d  = a;
          mag_d    = in_mag_b;
          sh_d     = in_mag_a;
          acc_d    = '0;
          busy_d   = 1'b1;
        end
      end

      RUN: begin
        if (op_q[1]) begin
          // Restoring divide: keep the trial difference unless it borrowed.
          if (!div_trial[WIDTH]) begin
            acc_d = div_trial[WIDTH-1:0];
            sh_d  = {sh_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = div_shift[WIDTH-1:0];
            sh_d  = {sh_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          // Shift-add multiply: the adder carry shifts into the top of acc.
          acc_d = mul_sum[WIDTH:1];
          sh_d  = {mul_sum[0], sh_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        dbz_d   = 1'b0;
        if (!op_q[1]) begin
          if (op_q[0] && signs_differ) begin
            hi_d = prod_neg[2*WIDTH-1:WIDTH];
            lo_d = prod_neg[WIDTH-1:0];
          end else begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end
        end else if (mag_q == '0) begin
          // A zero divisor reports the raw dividend and an all-ones quotient.
          hi_d  = a_raw_q;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else begin
          lo_d = (op_q[0] && signs_differ) ? quot_neg : sh_q;
          hi_d = (op_q[0] && sign_a_q) ? rem_neg : acc_q;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // All state and outputs are registered; reset aborts any operation at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= 2'b00;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      a_raw_q  <= '0;
      mag_q    <= '0;
      acc_q    <= '0;
      sh_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      a_raw_q  <= a_raw_d;
      mag_q    <= mag_d;
      acc_q    <= acc_d;
      sh_q     <= sh_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: a 32-bit and an 8-bit instance share clock and reset.
// An arithmetic model predicts every output on every cycle, and directed
// operations are also checked against hand-computed results.
module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start_s [2];
   logic [1:0]  op_s [2];
   logic [31:0] a_s [2];
   logic [31:0] b_s [2];

   logic        busy32, done32, dbz32;
   logic [31:0] hi32, lo32;
   logic        busy8, done8, dbz8;
   logic [7:0]  hi8, lo8;

   wire         busy_w [2];
   wire         done_w [2];
   wire         dbz_w [2];
   wire  [31:0] hi_w [2];
   wire  [31:0] lo_w [2];

   int nCompared = 0;
   int nMismatched = 0;

   // Model state per instance: pending result, remaining edges, visible result.
   logic [64:0] pendRes [2];
   logic [64:0] shownRes [2];
   logic        pending [2];
   logic        shownDone [2];
   int          remaining [2];

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   mul_div_unit #(.WIDTH(32)) dut32 (
      .clk(clk), .rst(rst), .start(start_s[0]), .op(op_s[0]),
      .a(a_s[0]), .b(b_s[0]), .busy(busy32), .done(done32),
      .hi(hi32), .lo(lo32), .div_by_zero(dbz32)
   );

   mul_div_unit #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start_s[1]), .op(op_s[1]),
      .a(a_s[1][7:0]), .b(b_s[1][7:0]), .busy(busy8), .done(done8),
      .hi(hi8), .lo(lo8), .div_by_zero(dbz8)
   );

   assign busy_w[0] = busy32;
   assign done_w[0] = done32;
   assign dbz_w[0]  = dbz32;
   assign hi_w[0]   = hi32;
   assign lo_w[0]   = lo32;
   assign busy_w[1] = busy8;
   assign done_w[1] = done8;
   assign dbz_w[1]  = dbz8;
   assign hi_w[1]   = {24'b0, hi8};
   assign lo_w[1]   = {24'b0, lo8};

   function automatic int widthOf(input int d);
      return (d == 0) ? 32 : 8;
   endfunction

   // Plain-arithmetic result of one operation, packed as {dbz, hi, lo}.
   function automatic logic [64:0] modelOp(input int w, input logic [1:0] op,
                                           input logic [31:0] a, input logic [31:0] b);
      longint mask, ua, ub, av, bv, q, r;
      logic [63:0] p;
      logic [31:0] hiV, loV;
      logic dbzV;
      mask = (longint'(1) << w) - 1;
      ua = longint'(a) & mask;
      ub = longint'(b) & mask;
      av = ua;
      bv = ub;
      if (op[0]) begin
         if (ua[w-1]) av = ua - (longint'(1) << w);
         if (ub[w-1]) bv = ub - (longint'(1) << w);
      end
      dbzV = 1'b0;
      if (!op[1]) begin
         p = 64'(av * bv);
         loV = 32'(p & 64'(mask));
         hiV = 32'((p >> w) & 64'(mask));
      end else if (bv == 0) begin
         loV = 32'(mask);
         hiV = 32'(ua);
         dbzV = 1'b1;
      end else begin
         q = av / bv;
         r = av % bv;
         loV = 32'(q & mask);
         hiV = 32'(r & mask);
      end
      return {dbzV, hiV, loV};
   endfunction

   // Single comparison point: bumps the counters and reports any difference.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Model timeline: an accepted start yields its result WIDTH+1 edges later;
   // starts while an operation is pending are ignored; reset drops everything.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int d = 0; d < 2; d++) begin
            pending[d]   <= 1'b0;
            shownDone[d] <= 1'b0;
            remaining[d] <= 0;
            pendRes[d]   <= '0;
            shownRes[d]  <= '0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            shownDone[d] <= 1'b0;
            if (pending[d]) begin
               if (remaining[d] == 1) begin
                  pending[d]   <= 1'b0;
                  shownDone[d] <= 1'b1;
                  shownRes[d]  <= pendRes[d];
               end else begin
                  remaining[d] <= remaining[d] - 1;
               end
            end else if (start_s[d]) begin
               pendRes[d]   <= modelOp(widthOf(d), op_s[d], a_s[d], b_s[d]);
               pending[d]   <= 1'b1;
               remaining[d] <= widthOf(d) + 1;
            end
         end
      end
   end

   // Every falling edge, both instances must match the model on all outputs.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         checkOutput($sformatf("cyc_d%0d_busy", d), {31'b0, busy_w[d]}, {31'b0, pending[d]});
         checkOutput($sformatf("cyc_d%0d_done", d), {31'b0, done_w[d]}, {31'b0, shownDone[d]});
         checkOutput($sformatf("cyc_d%0d_hi", d), hi_w[d], shownRes[d][63:32]);
         checkOutput($sformatf("cyc_d%0d_lo", d), lo_w[d], shownRes[d][31:0]);
         checkOutput($sformatf("cyc_d%0d_dbz", d), {31'b0, dbz_w[d]}, {31'b0, shownRes[d][64]});
      end
   end

   // Present one request for a single cycle; called on a falling edge.
   task automatic applyStimulus(input int d, input logic [1:0] op,
                                input logic [31:0] a, input logic [31:0] b);
      start_s[d] = 1'b1;
      op_s[d]    = op;
      a_s[d]     = a;
      b_s[d]     = b;
      @(negedge clk);
      start_s[d] = 1'b0;
   endtask

   // Run one operation, optionally poking start in RUN and FIX, and check the
   // latency and the final result against literal values.
   task automatic runOp(input int d, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] expHi,
                        input logic [31:0] expLo, input logic expDbz,
                        input string name, input bit intrude);
      int edges;
      int w;
      w = widthOf(d);
      edges = 0;
      applyStimulus(d, op, a, b);
      while (done_w[d] !== 1'b1 && edges < 200) begin
         @(negedge clk);
         edges++;
         if (intrude) begin
            if (edges == 5 || edges == w) begin
               start_s[d] = 1'b1;
               op_s[d]    = 2'b10;
               a_s[d]     = 32'h0000_0005;
               b_s[d]     = 32'h0000_0000;
            end else begin
               start_s[d] = 1'b0;
            end
         end
      end
      start_s[d] = 1'b0;
      checkOutput({name, "_latency"}, 32'(edges), 32'(w + 1));
      checkOutput({name, "_busy"}, {31'b0, busy_w[d]}, 32'h0);
      checkOutput({name, "_hi"}, hi_w[d], expHi);
      checkOutput({name, "_lo"}, lo_w[d], expLo);
      checkOutput({name, "_dbz"}, {31'b0, dbz_w[d]}, {31'b0, expDbz});
   endtask

   // Upper bound on run time so a stuck design still reaches a verdict.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence covering both widths, back-to-back, divide by zero,
   // overflow, ignored starts, retention and mid-operation reset.
   initial begin
      int doneCount;
      for (int d = 0; d < 2; d++) begin
         start_s[d] = 1'b0;
         op_s[d]    = 2'b00;
         a_s[d]     = 32'h0;
         b_s[d]     = 32'h0;
      end
      #1 rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checkOutput("reset_hi", hi32, 32'h0);
      checkOutput("reset_lo", lo32, 32'h0);
      checkOutput("reset_busy", {31'b0, busy32}, 32'h0);
      checkOutput("reset_done", {31'b0, done32}, 32'h0);
      checkOutput("reset_dbz", {31'b0, dbz32}, 32'h0);
      #3 rst = 1'b0;
      @(negedge clk);

      runOp(0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_max", 1'b0);
      @(negedge clk);
      runOp(0, 2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, "mult_neg", 1'b0);
      runOp(0, 2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_b2b", 1'b0);
      @(negedge clk);
      runOp(0, 2'b10, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, "divu_zero", 1'b0);
      @(negedge clk);
      runOp(0, 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "divu_100_7", 1'b0);
      @(negedge clk);
      runOp(0, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, "div_ovf", 1'b0);
      @(negedge clk);
      runOp(0, 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, "mult_minneg", 1'b0);
      @(negedge clk);
      runOp(0, 2'b11, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, "div_zero_signed", 1'b0);
      @(negedge clk);
      runOp(0, 2'b00, 32'd7, 32'd6, 32'h0, 32'h0000_002A, 1'b0, "multu_small", 1'b0);
      @(negedge clk);
      runOp(0, 2'b00, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0, 1'b0, "busy_start", 1'b1);

      runOp(1, 2'b01, 32'h80, 32'h80, 32'h40, 32'h00, 1'b0, "w8_mult", 1'b0);
      @(negedge clk);
      runOp(1, 2'b11, 32'h80, 32'h03, 32'hFE, 32'hD6, 1'b0, "w8_div", 1'b0);
      @(negedge clk);
      runOp(1, 2'b10, 32'hC8, 32'h07, 32'h04, 32'h1C, 1'b0, "w8_divu", 1'b0);
      @(negedge clk);
      runOp(1, 2'b00, 32'hFF, 32'hFF, 32'hFE, 32'h01, 1'b0, "w8_multu", 1'b0);

      repeat (5) @(negedge clk);
      checkOutput("retain_hi", hi32, 32'h1);
      checkOutput("retain_lo", lo32, 32'h0);

      applyStimulus(0, 2'b00, 32'd3, 32'd3);
      repeat (9) @(negedge clk);
      #3 rst = 1'b1;
      @(negedge clk);
      checkOutput("abort_hi", hi32, 32'h0);
      checkOutput("abort_lo", lo32, 32'h0);
      checkOutput("abort_busy", {31'b0, busy32}, 32'h0);
      checkOutput("abort_done", {31'b0, done32}, 32'h0);
      #3 rst = 1'b0;
      doneCount = 0;
      repeat (40) begin
         @(negedge clk);
         if (done32 === 1'b1) doneCount++;
      end
      checkOutput("abort_no_done", 32'(doneCount), 32'h0);

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
